// File: rtl/intra16_pkg.sv
// Shared constants, mode codes and FSM state encoding for the Intra 16x16
// mode scheduler and its row SAD/residual datapath.
package intra16_pkg;

    localparam int MB_ROWS   = 16;
    localparam int MB_COLS   = 16;
    localparam int MB_SAD_W  = 16;
    localparam int PIX_W     = 8;
    localparam int RES_W     = 9;
    localparam int ROW_SAD_W = 12;
    localparam int ROW_W     = 4;

    localparam logic [1:0] MODE_V  = 2'd0;
    localparam logic [1:0] MODE_H  = 2'd1;
    localparam logic [1:0] MODE_DC = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        S_REQ,
        S_WAIT,
        DECIDE,
        R_REQ,
        R_WAIT,
        R_PUSH,
        FIN
    } state_e;

endpackage

// File: rtl/intra16_row_sad.sv
// Combinational per-row datapath: 9-bit signed residual per lane and the
// sum of absolute differences across the row for one prediction mode.
module intra16_row_sad
    import intra16_pkg::*;
#(
    parameter int COLS = MB_COLS
) (
    input  logic [COLS*PIX_W-1:0]   src_i,
    input  logic [COLS*PIX_W-1:0]   pred_i,
    output logic [ROW_SAD_W-1:0]    sad_o,
    output logic [COLS*RES_W-1:0]   res_o
);

    logic [RES_W-1:0] diff;
    logic [RES_W-1:0] mag;

    // NOTE: every variable gets a default before the loop so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    always_comb begin
        sad_o = '0;
        res_o = '0;
        diff  = '0;
        mag   = '0;
        for (int c = 0; c < COLS; c++) begin
            // Zero-extending both operands makes the 9-bit wrap the exact
            // two's-complement difference in -255..+255.
            diff = {1'b0, src_i[c*PIX_W +: PIX_W]} - {1'b0, pred_i[c*PIX_W +: PIX_W]};
            mag  = diff[RES_W-1] ? -diff : diff;
            res_o[c*RES_W +: RES_W] = diff;
            sad_o = sad_o + ROW_SAD_W'(mag);
        end
    end

endmodule

// File: rtl/intra16_mode_sched.sv
// Two-pass Intra 16x16 scheduler: pass 1 accumulates V/H/DC SADs and picks
// the best mode, pass 2 streams that mode's residual rows with backpressure.
module intra16_mode_sched
    import intra16_pkg::*;
#(
    parameter int ROWS  = MB_ROWS,
    parameter int COLS  = MB_COLS,
    parameter int SAD_W = MB_SAD_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     rd_req,
    output logic                     rd_pass,
    output logic [ROW_W-1:0]         rd_addr,
    input  logic                     in_valid,
    input  logic [COLS*PIX_W-1:0]    mb_row,
    input  logic [COLS*PIX_W-1:0]    vpred_row,
    input  logic [COLS*PIX_W-1:0]    hpred_row,
    input  logic [COLS*PIX_W-1:0]    dcpred_row,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [COLS*RES_W-1:0]    res_row,
    output logic [ROW_W-1:0]         res_addr,
    output logic [SAD_W-1:0]         sad_v,
    output logic [SAD_W-1:0]         sad_h,
    output logic [SAD_W-1:0]         sad_dc,
    output logic [1:0]               best_mode,
    output logic                     done
);

    state_e                  state_q, state_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [SAD_W-1:0]        acc_v_q, acc_v_d, acc_h_q, acc_h_d, acc_dc_q, acc_dc_d;
    logic [SAD_W-1:0]        sad_v_q, sad_v_d, sad_h_q, sad_h_d, sad_dc_q, sad_dc_d;
    logic [1:0]              best_q, best_d;
    logic [COLS*RES_W-1:0]   res_row_q, res_row_d;
    logic [ROW_W-1:0]        res_addr_q, res_addr_d;
    logic                    busy_q, busy_d;

    logic [ROW_SAD_W-1:0]    rsad_v, rsad_h, rsad_dc;
    logic [COLS*RES_W-1:0]   res_v, res_h, res_dc, res_sel;
    logic                    last_row;

    intra16_row_sad #(.COLS(COLS)) u_sad_v  (.src_i(mb_row), .pred_i(vpred_row),  .sad_o(rsad_v),  .res_o(res_v));
    intra16_row_sad #(.COLS(COLS)) u_sad_h  (.src_i(mb_row), .pred_i(hpred_row),  .sad_o(rsad_h),  .res_o(res_h));
    intra16_row_sad #(.COLS(COLS)) u_sad_dc (.src_i(mb_row), .pred_i(dcpred_row), .sad_o(rsad_dc), .res_o(res_dc));

    assign last_row = (row_q == ROW_W'(ROWS-1));

    always_comb begin
        case (best_q)
            MODE_H:  res_sel = res_h;
            MODE_DC: res_sel = res_dc;
            default: res_sel = res_v;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        acc_v_d    = acc_v_q;
        acc_h_d    = acc_h_q;
        acc_dc_d   = acc_dc_q;
        sad_v_d    = sad_v_q;
        sad_h_d    = sad_h_q;
        sad_dc_d   = sad_dc_q;
        best_d     = best_q;
        res_row_d  = res_row_q;
        res_addr_d = res_addr_q;
        busy_d     = busy_q;

        case (state_q)
            IDLE: if (start) begin
                acc_v_d  = '0;
                acc_h_d  = '0;
                acc_dc_d = '0;
                row_d    = '0;
                busy_d   = 1'b1;
                state_d  = S_REQ;
            end
            S_REQ: state_d = S_WAIT;
            S_WAIT: if (in_valid) begin
                acc_v_d  = acc_v_q  + SAD_W'(rsad_v);
                acc_h_d  = acc_h_q  + SAD_W'(rsad_h);
                acc_dc_d = acc_dc_q + SAD_W'(rsad_dc);
                if (last_row) begin
                    state_d = DECIDE;
                end else begin
                    row_d   = row_q + 1'b1;
                    state_d = S_REQ;
                end
            end
            DECIDE: begin
                sad_v_d  = acc_v_q;
                sad_h_d  = acc_h_q;
                sad_dc_d = acc_dc_q;
                // Non-strict compares give ties to the lower mode index.
                if (acc_v_q <= acc_h_q && acc_v_q <= acc_dc_q) best_d = MODE_V;
                else if (acc_h_q <= acc_dc_q)                  best_d = MODE_H;
                else                                           best_d = MODE_DC;
                row_d   = '0;
                state_d = R_REQ;
            end
            R_REQ: state_d = R_WAIT;
            R_WAIT: if (in_valid) begin
                res_row_d  = res_sel;
                res_addr_d = row_q;
                state_d    = R_PUSH;
            end
            R_PUSH: if (res_ready) begin
                if (last_row) begin
                    state_d = FIN;
                end else begin
                    row_d   = row_q + 1'b1;
                    state_d = R_REQ;
                end
            end
            FIN: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            row_q      <= '0;
            acc_v_q    <= '0;
            acc_h_q    <= '0;
            acc_dc_q   <= '0;
            sad_v_q    <= '0;
            sad_h_q    <= '0;
            sad_dc_q   <= '0;
            best_q     <= MODE_V;
            res_row_q  <= '0;
            res_addr_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            acc_v_q    <= acc_v_d;
            acc_h_q    <= acc_h_d;
            acc_dc_q   <= acc_dc_d;
            sad_v_q    <= sad_v_d;
            sad_h_q    <= sad_h_d;
            sad_dc_q   <= sad_dc_d;
            best_q     <= best_d;
            res_row_q  <= res_row_d;
            res_addr_q <= res_addr_d;
            busy_q     <= busy_d;
        end
    end

    assign rd_req    = (state_q == S_REQ) || (state_q == R_REQ);
    assign rd_pass   = (state_q == R_REQ) || (state_q == R_WAIT);
    assign rd_addr   = rd_req ? row_q : '0;
    assign res_valid = (state_q == R_PUSH);
    assign res_row   = res_row_q;
    assign res_addr  = res_addr_q;
    assign sad_v     = sad_v_q;
    assign sad_h     = sad_h_q;
    assign sad_dc    = sad_dc_q;
    assign best_mode = best_q;
    assign busy      = busy_q;
    assign done      = (state_q == FIN);

endmodule

// File: tb/tb_intra16_mode_sched.sv
// Randomised self-checking bench for intra16_mode_sched: a fetch responder with
// configurable latency, a backpressuring residual sink and a plain SAD/residual model.
module tb_intra16_mode_sched;

    localparam int NR = 16;
    localparam int NC = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              res_ready = 1'b1;
    logic [NC*8-1:0]   mb_row = '0, vpred_row = '0, hpred_row = '0, dcpred_row = '0;
    logic              busy, rd_req, rd_pass, res_valid, done;
    logic [3:0]        rd_addr, res_addr;
    logic [NC*9-1:0]   res_row;
    logic [15:0]       sad_v, sad_h, sad_dc;
    logic [1:0]        best_mode;

    intra16_mode_sched dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .rd_req(rd_req), .rd_pass(rd_pass), .rd_addr(rd_addr),
        .in_valid(in_valid), .mb_row(mb_row), .vpred_row(vpred_row),
        .hpred_row(hpred_row), .dcpred_row(dcpred_row),
        .res_valid(res_valid), .res_ready(res_ready), .res_row(res_row),
        .res_addr(res_addr), .sad_v(sad_v), .sad_h(sad_h), .sad_dc(sad_dc),
        .best_mode(best_mode), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Macroblock stimulus: source and the three predictions, per row/column.
    int src [NR][NC];
    int pv  [NR][NC];
    int ph  [NR][NC];
    int pd  [NR][NC];
    int esad [3];
    int ebest;

    function automatic int pred(int m, int r, int c);
        if (m == 0) return pv[r][c];
        if (m == 1) return ph[r][c];
        return pd[r][c];
    endfunction

    task automatic fill_const(int m, int v, int h, int d);
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++) begin
                src[r][c] = m; pv[r][c] = v; ph[r][c] = h; pd[r][c] = d;
            end
    endtask

    task automatic fill_rand();
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++) begin
                src[r][c] = int'($urandom_range(0, 255));
                pv[r][c]  = int'($urandom_range(0, 255));
                ph[r][c]  = int'($urandom_range(0, 255));
                pd[r][c]  = int'($urandom_range(0, 255));
            end
    endtask

    task automatic model();
        for (int m = 0; m < 3; m++) begin
            esad[m] = 0;
            for (int r = 0; r < NR; r++)
                for (int c = 0; c < NC; c++) begin
                    int d;
                    d = src[r][c] - pred(m, r, c);
                    esad[m] += (d < 0) ? -d : d;
                end
        end
        ebest = 0;
        if (esad[1] < esad[ebest]) ebest = 1;
        if (esad[2] < esad[ebest]) ebest = 2;
    endtask

    // Fetch responder and its protocol observations.
    int fetch_lat = 0;
    int extra_req = 0;
    int nf0 = 0, nf1 = 0, addr_err = 0;
    bit spur_en = 1'b0, spur_done = 1'b0;
    int stall_row = -1, stall_len = 0, stall_cnt = 0;

    task automatic drive_rows(int a);
        for (int c = 0; c < NC; c++) begin
            mb_row[c*8 +: 8]     = 8'(src[a][c]);
            vpred_row[c*8 +: 8]  = 8'(pv[a][c]);
            hpred_row[c*8 +: 8]  = 8'(ph[a][c]);
            dcpred_row[c*8 +: 8] = 8'(pd[a][c]);
        end
    endtask

    initial begin
        int a;
        forever begin
            @(negedge clk);
            if (rd_req) begin
                a = int'(rd_addr);
                if (rd_pass) begin
                    if (a != nf1) addr_err++;
                    nf1++;
                end else begin
                    if (a != nf0) addr_err++;
                    nf0++;
                end
                for (int i = 0; i < fetch_lat; i++) begin
                    @(negedge clk);
                    if (rd_req) extra_req++;
                end
                @(posedge clk); #1;
                in_valid = 1'b1;
                drive_rows(a);
                @(negedge clk);
                if (rd_req) extra_req++;
                @(posedge clk); #1;
                in_valid = 1'b0;
            end else if (spur_en && !spur_done && res_valid && int'(res_addr) == stall_row) begin
                spur_done = 1'b1;
                @(posedge clk); #1;
                in_valid   = 1'b1;
                mb_row     = {NC{8'h5A}};
                vpred_row  = {NC{8'hC3}};
                hpred_row  = {NC{8'h11}};
                dcpred_row = {NC{8'hEE}};
                @(posedge clk); #1;
                in_valid = 1'b0;
            end
        end
    end

    // Residual sink: applies backpressure, records accepted rows, watches stability.
    logic [NC*9-1:0] got_rows [$];
    int              got_addr [$];
    int              unstable = 0;
    int              done_cnt = 0;
    bit              hold = 1'b0;
    logic [NC*9-1:0] prev_row = '0;
    logic [3:0]      prev_addr = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (res_valid && int'(res_addr) == stall_row && stall_cnt < stall_len) begin
                res_ready = 1'b0;
                stall_cnt++;
            end else begin
                res_ready = 1'b1;
            end
            if (res_valid) begin
                if (hold && (res_row !== prev_row || res_addr !== prev_addr)) unstable++;
                if (res_ready) begin
                    got_rows.push_back(res_row);
                    got_addr.push_back(int'(res_addr));
                end
                hold      = !res_ready;
                prev_row  = res_row;
                prev_addr = res_addr;
            end else begin
                hold = 1'b0;
            end
            if (done) done_cnt++;
        end
    end

    task automatic prep(int lat, int srow, int slen, bit spur);
        fetch_lat = lat; stall_row = srow; stall_len = slen; stall_cnt = 0;
        spur_en = spur; spur_done = 1'b0; extra_req = 0;
        nf0 = 0; nf1 = 0; addr_err = 0; unstable = 0; done_cnt = 0;
        got_rows.delete(); got_addr.delete();
        model();
    endtask

    task automatic check_zero(input string name);
        check({name, ":busy"},      64'(busy), 0);
        check({name, ":rd_req"},    64'(rd_req), 0);
        check({name, ":rd_pass"},   64'(rd_pass), 0);
        check({name, ":rd_addr"},   64'(rd_addr), 0);
        check({name, ":res_valid"}, 64'(res_valid), 0);
        check({name, ":res_row"},   64'(res_row !== '0), 0);
        check({name, ":res_addr"},  64'(res_addr), 0);
        check({name, ":sad_v"},     64'(sad_v), 0);
        check({name, ":sad_h"},     64'(sad_h), 0);
        check({name, ":sad_dc"},    64'(sad_dc), 0);
        check({name, ":best"},      64'(best_mode), 0);
        check({name, ":done"},      64'(done), 0);
    endtask

    task automatic run_mb(input string name, int lat, int srow, int slen, bit spur,
                          bit mid_start, int exp_lat);
        int n;
        bit seen;
        prep(lat, srow, slen, spur);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check({name, ":busy_after_start"}, 64'(busy), 1);
        n = 0;
        seen = 1'b0;
        while (n < 3000) begin
            @(negedge clk);
            n++;
            if (mid_start) start = (n == 10);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, ":done_seen"}, 64'(seen), 1);
        if (exp_lat > 0) check({name, ":latency"}, 64'(n), 64'(exp_lat));
        // A start coinciding with done must be ignored.
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(negedge clk);
        check({name, ":busy_idle"},   64'(busy), 0);
        check({name, ":done_pulses"}, 64'(done_cnt), 1);
        check({name, ":sad_v"},  64'(sad_v),  64'(esad[0]));
        check({name, ":sad_h"},  64'(sad_h),  64'(esad[1]));
        check({name, ":sad_dc"}, 64'(sad_dc), 64'(esad[2]));
        check({name, ":best"},   64'(best_mode), 64'(ebest));
        check({name, ":pass1_fetches"}, 64'(nf0), NR);
        check({name, ":pass2_fetches"}, 64'(nf1), NR);
        check({name, ":fetch_order"},   64'(addr_err), 0);
        check({name, ":one_outstanding"}, 64'(extra_req), 0);
        check({name, ":stable_hold"},   64'(unstable), 0);
        if (slen > 0) check({name, ":stall_applied"}, 64'(stall_cnt), 64'(slen));
        if (spur) check({name, ":spur_sent"}, 64'(spur_done), 1);
        check({name, ":rows"}, 64'(got_rows.size()), NR);
        for (int i = 0; i < NR && i < got_rows.size(); i++) begin
            logic [NC*9-1:0] r;
            r = got_rows[i];
            check($sformatf("%s:res_addr%0d", name, i), 64'(got_addr[i]), 64'(i));
            for (int c = 0; c < NC; c++) begin
                logic [8:0] e;
                e = 9'(src[i][c] - pred(ebest, i, c));
                check($sformatf("%s:res r%0d c%0d", name, i, c), 64'(r[c*9 +: 9]), 64'(e));
            end
        end
    endtask

    task automatic run_reset_mid(input string name);
        int n;
        prep(1, -1, 0, 1'b0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (n < 1000 && !(res_valid && res_addr == 4'd5)) begin
            @(negedge clk);
            n++;
        end
        check({name, ":reached_row5"}, 64'(n < 1000), 1);
        reset = 1'b0;
        #1;
        check_zero({name, ":in_reset"});
        repeat (4) @(negedge clk);
        check({name, ":no_done"}, 64'(done_cnt), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        fill_const(100, 100, 90, 110);
        run_mb("flat", 0, -1, 0, 1'b0, 1'b0, 82);

        fill_const(200, 0, 0, 201);
        run_mb("dc_best", 0, -1, 0, 1'b0, 1'b0, 82);

        fill_const(50, 0, 50, 50);
        run_mb("tie_h_dc", 0, -1, 0, 1'b0, 1'b0, 82);

        fill_const(0, 255, 255, 255);
        run_mb("max_sad", 0, -1, 0, 1'b0, 1'b0, 82);

        fill_rand();
        run_mb("lat3_stall7", 3, 7, 5, 1'b0, 1'b0, 0);

        fill_rand();
        run_mb("clean", 1, -1, 0, 1'b0, 1'b0, 0);
        run_mb("perturbed", 1, 3, 5, 1'b1, 1'b1, 0);

        fill_rand();
        run_reset_mid("rst_mid");
        run_mb("after_reset", 0, -1, 0, 1'b0, 1'b0, 82);

        for (int k = 0; k < 4; k++) begin
            int lat;
            lat = int'($urandom_range(0, 2));
            fill_rand();
            run_mb($sformatf("rand%0d", k), lat, int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 3)), 1'b0, 1'b0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/intra16_mode_sched.md
Name: intra16_mode_sched

Overview:
- Sequences the Intra 16x16 luma residual path for one macroblock at a time, in two passes over 16 rows.
- Pass 1 fetches the source rows and the V, H and DC predicted rows, and accumulates a per-mode SAD.
- It then selects the best mode.
- Pass 2 re-fetches the rows and streams the signed residual of the chosen mode to the transform stage, with backpressure.
- Sits between the prediction buffers and the forward transform.

Parameters:
- ROWS, 16, rows per macroblock.
- COLS, 16, samples per row.
- SAD_W, 16, SAD accumulator width; 16*16*255 = 65280 fits.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a macroblock; ignored while busy=1.
- busy  out  1  high from the cycle after an accepted start until done.
- rd_req  out  1  row fetch request.
- rd_pass  out  1  0 = pass 1 (SAD), 1 = pass 2 (residual).
- rd_addr  out  4  row index of the fetch.
- in_valid  in  1  fetched row data valid; variable latency, at most one fetch outstanding.
- mb_row  in  COLS*8  source row; sample c is at bits [8c+7:8c].
- vpred_row  in  COLS*8  vertical prediction row.
- hpred_row  in  COLS*8  horizontal prediction row.
- dcpred_row  in  COLS*8  DC prediction row.
- res_valid  out  1  residual row valid.
- res_ready  in  1  downstream ready.
- res_row  out  COLS*9  signed residual row; sample c is at bits [9c+8:9c].
- res_addr  out  4  row index of res_row.
- sad_v  out  SAD_W  final SAD for vertical mode.
- sad_h  out  SAD_W  final SAD for horizontal mode.
- sad_dc  out  SAD_W  final SAD for DC mode.
- best_mode  out  2  0 = V, 1 = H, 2 = DC.
- done  out  1  one-cycle pulse after the last residual row is accepted.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All outputs 0: rd_req, rd_pass, rd_addr, res_valid, res_row, res_addr, sad_*, best_mode, busy, done.
- States: IDLE, S_REQ, S_WAIT, DECIDE, R_REQ, R_WAIT, R_PUSH, FIN.
- IDLE:
  - On start: clear all three SAD accumulators and the row counter, busy<=1, go to S_REQ.
- S_REQ:
  - Drive rd_req=1, rd_pass=0, rd_addr=row for exactly one cycle, then go to S_WAIT.
- S_WAIT:
  - rd_req=0. On in_valid, add the row SAD to each accumulator. Row SAD is the sum over c of |mb - pred|, computed on 9-bit signed differences.
  - If row==ROWS-1, go to DECIDE; otherwise row++ and go to S_REQ.
  - in_valid outside S_WAIT/R_WAIT is ignored.
- DECIDE (1 cycle):
  - Register sad_v, sad_h, sad_dc.
  - best_mode = the minimum SAD. Ties resolve to the lowest mode index (V beats H beats DC).
  - Row counter <= 0, go to R_REQ.
- R_REQ / R_WAIT:
  - Same fetch protocol as pass 1 with rd_pass=1.
  - On in_valid, latch res_row = mb - pred(best_mode), sign-extended to 9 bits per sample, and res_addr=row.
  - res_valid<=1, go to R_PUSH.
- R_PUSH:
  - Hold res_row, res_addr and res_valid stable until res_ready=1.
  - On the handshake cycle: res_valid<=0. If row==ROWS-1, go to FIN; otherwise row++ and go to R_REQ.
- FIN:
  - done=1 for one cycle, busy<=0, go to IDLE.
  - sad_* and best_mode hold until the next accepted start.
- Latency with zero-latency fetch and res_ready tied 1: 16*2 + 1 + 16*3 + 1 = 82 cycles from start to done.
- Reset mid-operation discards the macroblock immediately; no done pulse is produced.
- A start pulse arriving in the same cycle as done (FIN) is ignored; start is accepted only in IDLE.
- Arithmetic:
  - No wrap in SAD (the width is sufficient).
  - Residual range is -255..+255; no 8-bit truncation.

Decomposition:
- Package intra16_pkg:
  - Mode constants MODE_V=0, MODE_H=1, MODE_DC=2.
  - State enum.
  - Localparams for the row and sample widths.
- Sub-module intra16_row_sad:
  - Combinational.
  - Inputs: one source row and one prediction row.
  - Outputs: a 12-bit row SAD and the 16-lane residual vector.
  - Instantiated three times (V, H, DC); pass 2 muxes the residual vectors by best_mode.

Test Plan:
- All mb=100, V pred=100, H pred=90, DC pred=110, zero-latency fetch, ready=1 -> sad_v=0, sad_h=2560, sad_dc=2560, best_mode=0, every res_row all zero, done exactly 82 cycles after start.
- mb=200, all preds=0 except DC pred=201 -> sad_dc=256, V and H sad=51200, best_mode=2, every residual sample = -1 (9'h1FF).
- sad_h == sad_dc < sad_v (H=DC=50, V=0, mb=50) -> best_mode=1 by tie rule.
- in_valid delayed 3 cycles per fetch, res_ready low 5 cycles on row 7 -> res_row/res_addr=7 held stable throughout, only one rd_req outstanding, all 16 residual rows delivered in order 0..15.
- Extra start pulse in the middle of pass 1, plus a spurious in_valid while in R_PUSH -> both ignored, results unchanged from the unperturbed run.
- reset asserted during pass 2 row 5, then released and start reissued -> outputs 0 immediately, no done pulse, the new run completes with correct values.
